// File: rtl/bram_stream_reader.sv
// Drains a length-prefixed tile codestream from a 32-bit BRAM and emits it as a
// valid/ready byte stream, most significant byte of each word first.
module bram_stream_reader #(
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0,
  parameter int MAX_BYTES = 65532
) (
  input  logic              clk_100,
  input  logic              rst,
  input  logic              tile_start,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [31:0]       bram_dout,
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic              tile_done,
  output logic              len_err,
  output logic [15:0]       tile_count
);

  typedef enum logic [2:0] {
    IDLE, LEN_RD, LEN_WAIT, WORD_RD, WORD_WAIT, SEND, DONE
  } state_t;

  localparam logic [31:0]       MAX_LEN   = MAX_BYTES;
  localparam logic [ADDR_W-1:0] HDR_ADDR  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] DATA_ADDR = ADDR_W'(BASE_ADDR + 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [17:0] r_remaining;
  logic [15:0] r_word_idx;
  logic [1:0]  r_byte_sel;
  logic [31:0] r_word;
  logic        r_len_err;
  logic [15:0] r_tile_count;

  logic [17:0]       w_len;
  logic              w_len_bad;
  logic              w_xfer;
  logic              w_last_byte;
  logic [ADDR_W-1:0] w_word_addr;

  assign w_len       = bram_dout[17:0];
  assign w_len_bad   = {14'd0, w_len} > MAX_LEN;
  assign w_xfer      = (r_state == SEND) && byte_ready;
  assign w_last_byte = (r_remaining == 18'd1);
  assign w_word_addr = DATA_ADDR + ADDR_W'(r_word_idx);

  assign len_err    = r_len_err;
  assign tile_count = r_tile_count;

  always_ff @(posedge clk_100 or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:      if (tile_start) w_state_next = LEN_RD;
      LEN_RD:    w_state_next = LEN_WAIT;
      LEN_WAIT: begin
        if (w_len == 18'd0 || w_len_bad) begin
          w_state_next = DONE;
        end else begin
          w_state_next = WORD_RD;
        end
      end
      WORD_RD:   w_state_next = WORD_WAIT;
      WORD_WAIT: w_state_next = SEND;
      SEND: begin
        // A short final word ends here too: its low bytes are never presented.
        if (w_xfer) begin
          if (w_last_byte) begin
            w_state_next = DONE;
          end else if (r_byte_sel == 2'd3) begin
            w_state_next = WORD_RD;
          end
        end
      end
      DONE:      w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  always_comb begin
    bram_en    = 1'b0;
    bram_addr  = '0;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    busy       = 1'b0;
    tile_done  = 1'b0;
    case (r_state)
      LEN_RD: begin
        bram_en   = 1'b1;
        bram_addr = HDR_ADDR;
        busy      = 1'b1;
      end
      LEN_WAIT:  busy = 1'b1;
      WORD_RD: begin
        bram_en   = 1'b1;
        bram_addr = w_word_addr;
        busy      = 1'b1;
      end
      WORD_WAIT: busy = 1'b1;
      SEND: begin
        byte_valid = 1'b1;
        busy       = 1'b1;
        case (r_byte_sel)
          2'd0:    byte_data = r_word[31:24];
          2'd1:    byte_data = r_word[23:16];
          2'd2:    byte_data = r_word[15:8];
          default: byte_data = r_word[7:0];
        endcase
      end
      DONE:      tile_done = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk_100 or negedge rst) begin
    if (!rst) begin
      r_remaining  <= '0;
      r_word_idx   <= '0;
      r_byte_sel   <= '0;
      r_word       <= '0;
      r_len_err    <= 1'b0;
      r_tile_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (tile_start) begin
            r_remaining <= '0;
            r_word_idx  <= '0;
            r_byte_sel  <= '0;
          end
        end
        LEN_WAIT: begin
          r_remaining <= w_len;
          if (w_len_bad) r_len_err <= 1'b1;
        end
        WORD_WAIT: begin
          r_word     <= bram_dout;
          r_byte_sel <= 2'd0;
        end
        SEND: begin
          if (w_xfer) begin
            r_remaining <= r_remaining - 18'd1;
            r_byte_sel  <= r_byte_sel + 2'd1;
            if (r_byte_sel == 2'd3) r_word_idx <= r_word_idx + 16'd1;
          end
        end
        DONE:    r_tile_count <= r_tile_count + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: table of directed tiles, randomized
// tiles with random back-pressure, and reset-abandon sequences against a byte model.
`timescale 1ns/1ps
module tb_bram_stream_reader;

  localparam int ADDR_W = 16;
  localparam int BASE   = 100;
  localparam int MAXB   = 65532;

  logic              clk_100    = 1'b0;
  logic              rst        = 1'b0;
  logic              tile_start = 1'b0;
  logic              byte_ready = 1'b0;
  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [31:0]       bram_dout  = 32'd0;
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              busy;
  logic              tile_done;
  logic              len_err;
  logic [15:0]       tile_count;

  bram_stream_reader #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MAX_BYTES(MAXB)
  ) dut (
    .clk_100(clk_100), .rst(rst), .tile_start(tile_start),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .busy(busy), .tile_done(tile_done), .len_err(len_err), .tile_count(tile_count)
  );

  always #5 clk_100 = ~clk_100;

  // BRAM model: one-cycle registered read
  logic [31:0] mem [0:255];
  always @(posedge clk_100) if (bram_en) bram_dout <= mem[bram_addr[7:0]];

  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] exp_tiles = 16'd0;
  logic        exp_err = 1'b0;
  logic [7:0]  got_bytes [$];
  int          got_addrs [$];
  logic        stall_prev = 1'b0;
  logic [7:0]  stall_data = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Byte i of the tile as laid out in memory
  function automatic logic [7:0] model_byte(input int i);
    logic [31:0] w;
    w = mem[BASE + 1 + i / 4];
    return 8'(w >> (24 - 8 * (i % 4)));
  endfunction

  always @(negedge clk_100) begin
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 32'(byte_valid), 32'd1);
        check("hold_data", 32'(byte_data), 32'(stall_data));
      end
      if (byte_valid && byte_ready) got_bytes.push_back(byte_data);
      if (bram_en) got_addrs.push_back(int'(bram_addr));
      stall_prev = byte_valid && !byte_ready;
      stall_data = byte_data;
    end
  end

  task automatic run_tile(input int len, input bit rr, input int extra_k,
                          output int busy_n, output int done_k, output int first_k);
    int k, done_n, bound, nexp, nreads;
    mem[BASE] = ($urandom() & 32'hFFFC0000) | 32'(len);
    got_bytes.delete();
    got_addrs.delete();
    busy_n = 0; done_k = -1; first_k = -1; done_n = 0; k = 0;
    bound = (len > 0 && len <= MAXB) ? 60 + 8 * len : 60;
    @(posedge clk_100); #1;
    tile_start = 1'b1;
    byte_ready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
    while (k < bound) begin
      @(posedge clk_100); #1;
      k++;
      tile_start = (extra_k != 0 && k == extra_k);
      byte_ready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
      if (busy) busy_n++;
      if (tile_done) begin
        done_n++;
        if (done_k < 0) done_k = k;
      end
      if (byte_valid && first_k < 0) first_k = k;
      if (done_k >= 0 && k >= done_k + 4) break;
    end
    tile_start = 1'b0;
    if (done_k < 0) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      nexp   = (len > 0 && len <= MAXB) ? len : 0;
      nreads = (nexp > 0) ? 1 + (nexp + 3) / 4 : 1;
      if (len > MAXB) exp_err = 1'b1;
      exp_tiles = exp_tiles + 16'd1;
      check("done_pulses", 32'(done_n), 32'd1);
      check("busy_end", 32'(busy), 32'd0);
      check("byte_count", 32'(got_bytes.size()), 32'(nexp));
      for (int i = 0; i < nexp && i < got_bytes.size(); i++)
        check("byte", 32'(got_bytes[i]), 32'(model_byte(i)));
      check("read_count", 32'(got_addrs.size()), 32'(nreads));
      for (int i = 0; i < nreads && i < got_addrs.size(); i++)
        check("read_addr", 32'(got_addrs[i]), 32'(BASE + i));
      check("tile_count", 32'(tile_count), 32'(exp_tiles));
      check("len_err", 32'(len_err), 32'(exp_err));
    end
    $display("tile len=%0d ready_rand=%0d bytes=%0d busy=%0d done_at=%0d first_at=%0d",
             len, rr, got_bytes.size(), busy_n, done_k, first_k);
  endtask

  typedef struct {
    int          len;
    logic [31:0] w0;
    logic [31:0] w1;
    int          exp_busy;
    int          exp_done;
    int          exp_first;
  } vec_t;

  initial begin
    vec_t tbl [7];
    int   bn, dk, fk, len;

    tbl[0] = '{8,        32'h11223344, 32'h55667788, 14, 15, 5};
    tbl[1] = '{5,        32'hAABBCCDD, 32'hEEFF0011, 11, 12, 5};
    tbl[2] = '{0,        32'hDEADBEEF, 32'h01020304,  2,  3, -1};
    tbl[3] = '{1,        32'h5A000000, 32'h00000000,  5,  6, 5};
    tbl[4] = '{3,        32'hC0FFEE12, 32'h34343434,  7,  8, 5};
    tbl[5] = '{MAXB + 1, 32'h99999999, 32'h88888888,  2,  3, -1};
    tbl[6] = '{4,        32'h0A0B0C0D, 32'hFFFFFFFF,  8,  9, 5};

    for (int i = 0; i < 256; i++) mem[i] = $urandom();

    // reset state
    repeat (3) @(posedge clk_100);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(byte_valid), 32'd0);
    check("rst_bram_en", 32'(bram_en), 32'd0);
    check("rst_tile_count", 32'(tile_count), 32'd0);
    check("rst_len_err", 32'(len_err), 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk_100);

    foreach (tbl[i]) begin
      mem[BASE + 1] = tbl[i].w0;
      mem[BASE + 2] = tbl[i].w1;
      run_tile(tbl[i].len, 1'b0, 0, bn, dk, fk);
      check("busy_cycles", 32'(bn), 32'(tbl[i].exp_busy));
      check("done_latency", 32'(dk), 32'(tbl[i].exp_done));
      check("first_valid", 32'(fk), 32'(tbl[i].exp_first));
    end

    // tile_start landing in the DONE cycle must not start another tile
    mem[BASE + 1] = 32'h77665544;
    run_tile(1, 1'b0, 6, bn, dk, fk);
    check("done_cycle_start_busy", 32'(bn), 32'd5);

    // back-pressure with a stray tile_start mid-stream
    mem[BASE + 1] = $urandom();
    run_tile(4, 1'b1, 7, bn, dk, fk);

    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(1, 40);
      for (int w = 1; w <= 10; w++) mem[BASE + w] = $urandom();
      run_tile(len, 1'b1, (len >= 4) ? 7 : 0, bn, dk, fk);
    end

    // reset after two bytes of an 8-byte tile
    mem[BASE] = 32'd8;
    mem[BASE + 1] = $urandom();
    mem[BASE + 2] = $urandom();
    got_bytes.delete();
    @(posedge clk_100); #1;
    tile_start = 1'b1;
    byte_ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk_100); #1;
      tile_start = 1'b0;
    end
    rst = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(byte_valid), 32'd0);
    check("arst_data", 32'(byte_data), 32'd0);
    check("arst_bram_en", 32'(bram_en), 32'd0);
    check("arst_bram_addr", 32'(bram_addr), 32'd0);
    check("arst_tile_done", 32'(tile_done), 32'd0);
    check("arst_len_err", 32'(len_err), 32'd0);
    check("arst_tile_count", 32'(tile_count), 32'd0);
    check("bytes_before_reset", 32'(got_bytes.size()), 32'd2);
    for (int i = 0; i < 2 && i < got_bytes.size(); i++)
      check("byte_before_reset", 32'(got_bytes[i]), 32'(model_byte(i)));
    $display("reset mid-tile after %0d bytes", got_bytes.size());
    repeat (3) begin
      @(posedge clk_100); #1;
      check("no_done_in_reset", 32'(tile_done), 32'd0);
    end
    rst = 1'b1;
    exp_tiles = 16'd0;
    exp_err = 1'b0;
    repeat (3) begin
      @(posedge clk_100); #1;
      check("idle_after_release", 32'(busy), 32'd0);
    end
    mem[BASE + 1] = 32'hF00DCAFE;
    run_tile(4, 1'b0, 0, bn, dk, fk);
    check("post_reset_busy", 32'(bn), 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
